// File: rtl/memory_reader.sv
// Steps through a packed memory word one 4-bit entry at a time, manually or by timed playback,
// and drives addr/num onto the 24-bit digit / 6-bit enable display bus. Option macro: MEMORY_READER_LOOP_EN.
module memory_reader #(
  parameter int WIDTH = 40,
  parameter int TICKS = 50_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             nxt,
  input  logic [WIDTH-1:0] mem,
  output logic [3:0]       addr,
  output logic [3:0]       num,
  output logic             wrap,
  output logic [23:0]      d,
  output logic [5:0]       e
);

  localparam int N  = WIDTH / 4;
  localparam int CW = $clog2(TICKS);
  localparam int IW = $clog2(WIDTH);
  localparam logic [3:0]    LAST = 4'(N - 1);
  localparam logic [CW-1:0] CMAX = CW'(TICKS - 1);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    addr_q, addr_d;
  logic [3:0]    num_q, num_d;
  logic          wrap_q, wrap_d;
  logic          adv;
  logic          expire;
  logic          play_ok;
  logic [IW-1:0] nib_idx;

  function automatic logic [3:0] next_addr(input logic [3:0] a);
    return (a == LAST) ? 4'd0 : a + 4'd1;
  endfunction

`ifdef MEMORY_READER_LOOP_EN
  assign play_ok = 1'b1;
`else
  // Set when playback stops itself at the end of memory; cleared once run drops,
  // so only a fresh rising edge of run can restart playback.
  logic halt_q, halt_d;
  assign play_ok = ~halt_q;
`endif

  assign expire = (cnt_q == CMAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adv     = 1'b0;
`ifndef MEMORY_READER_LOOP_EN
    halt_d  = halt_q & run;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        adv   = nxt;
        if (run && play_ok) state_d = PLAY;
      end
      PLAY: begin
        if (!run) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (nxt || expire) begin
          adv   = 1'b1;
          cnt_d = '0;
`ifndef MEMORY_READER_LOOP_EN
          if (expire && addr_q == LAST) begin
            state_d = IDLE;
            halt_d  = 1'b1;
          end
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    addr_d  = adv ? next_addr(addr_q) : addr_q;
    wrap_d  = adv && (addr_q == LAST);
    nib_idx = IW'({addr_d, 2'b00});
    num_d   = mem[nib_idx +: 4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= 4'd0;
      num_q   <= 4'd0;
      wrap_q  <= 1'b0;
`ifndef MEMORY_READER_LOOP_EN
      halt_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      num_q   <= num_d;
      wrap_q  <= wrap_d;
`ifndef MEMORY_READER_LOOP_EN
      halt_q  <= halt_d;
`endif
    end
  end

  assign addr = addr_q;
  assign num  = num_q;
  assign wrap = wrap_q;
  assign d    = {4'b0000, addr_q, 12'h000, num_q};
  assign e    = 6'b010001;

endmodule

// File: tb/tb_memory_reader.sv
// Directed scoreboard bench for memory_reader with WIDTH=40, TICKS=4 and entry k = k.
module tb_memory_reader;

  localparam int WIDTH = 40;
  localparam int TICKS = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             run;
  logic             nxt;
  logic [WIDTH-1:0] mem;
  logic [3:0]       addr;
  logic [3:0]       num;
  logic             wrap;
  logic [23:0]      d;
  logic [5:0]       e;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] n;
    logic       w;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle_no = 0;

  memory_reader #(.WIDTH(WIDTH), .TICKS(TICKS)) dut (
    .clk  (clk),
    .reset(reset),
    .run  (run),
    .nxt  (nxt),
    .mem  (mem),
    .addr (addr),
    .num  (num),
    .wrap (wrap),
    .d    (d),
    .e    (e)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cycle_no, got, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue what the outputs must show after the edge.
  task automatic cyc(input logic rs, input logic r, input logic n,
                     input logic [3:0] ea, input logic ew);
    exp_t x;
    logic [WIDTH-1:0] m;
    reset = rs;
    run   = r;
    nxt   = n;
    m     = mem;
    x.a   = ea;
    x.n   = rs ? 4'd0 : m[ea*4 +: 4];
    x.w   = ew;
    sb.push_back(x);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t x;
    #1;
    cycle_no++;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check_eq("addr", 32'(addr), 32'(x.a));
      check_eq("num",  32'(num),  32'(x.n));
      check_eq("wrap", 32'(wrap), 32'(x.w));
      check_eq("d",    32'(d),    32'({4'b0, x.a, 12'h000, x.n}));
      check_eq("e",    32'(e),    32'(6'b010001));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cycle_no);
    $fatal(1, "watchdog expired");
  end

  initial begin
    mem = 40'h98765_43210;
    // reset held two cycles, then released idle
    cyc(1, 0, 0, 4'd0, 0);
    cyc(1, 0, 0, 4'd0, 0);
    cyc(0, 0, 0, 4'd0, 0);

    // manual stepping in IDLE, wrap on the tenth step only
    for (int i = 1; i <= 10; i++) begin
      cyc(0, 0, 1, 4'(i % 10), i == 10);
      cyc(0, 0, 0, 4'(i % 10), 0);
      cyc(0, 0, 0, 4'(i % 10), 0);
    end

    // playback: enter PLAY, then one advance every TICKS edges
    cyc(0, 1, 0, 4'd0, 0);
    for (int k = 1; k <= 20; k++) cyc(0, 1, 0, 4'(k / TICKS), 0);

    // nxt at cnt=2 advances immediately and restarts the dwell
    cyc(0, 1, 0, 4'd5, 0);
    cyc(0, 1, 0, 4'd5, 0);
    cyc(0, 1, 1, 4'd6, 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 4'd6, 0);
    cyc(0, 1, 0, 4'd7, 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 4'd7, 0);
    // nxt coincident with dwell expiry: exactly one advance
    cyc(0, 1, 1, 4'd8, 0);

    // playback across the end of memory
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 4'd8, 0);
    cyc(0, 1, 0, 4'd9, 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 4'd9, 0);
    cyc(0, 1, 0, 4'd0, 1);
`ifdef MEMORY_READER_LOOP_EN
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 4'd0, 0);
    cyc(0, 1, 0, 4'd1, 0);
`else
    // stopped: run still high must not restart playback
    for (int k = 0; k < 8; k++) cyc(0, 1, 0, 4'd0, 0);
    cyc(0, 0, 0, 4'd0, 0);
    cyc(0, 1, 0, 4'd0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 4'd0, 0);
    cyc(0, 1, 0, 4'd1, 0);
`endif

    // advance to addr 3, then change entry 3 under it
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 4'd1, 0);
    cyc(0, 1, 0, 4'd2, 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 4'd2, 0);
    cyc(0, 1, 0, 4'd3, 0);
    mem[15:12] = 4'hF;
    cyc(0, 1, 0, 4'd3, 0);
    for (int k = 0; k < 2; k++) cyc(0, 1, 0, 4'd3, 0);
    cyc(0, 1, 0, 4'd4, 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 4'd4, 0);
    cyc(0, 1, 0, 4'd5, 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 4'd5, 0);
    cyc(0, 1, 0, 4'd6, 0);

    // reset during playback with run still high, then playback restarts from 0
    cyc(1, 1, 0, 4'd0, 0);
    cyc(0, 1, 0, 4'd0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 4'd0, 0);
    cyc(0, 1, 0, 4'd1, 0);
    cyc(0, 1, 0, 4'd1, 0);

    // run dropped: hold in IDLE with no advance
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 4'd1, 0);

    @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      check_eq("drain", 32'(sb.size()), 32'd0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
